ifetch_stage: RTL
=================

// Module: ifetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the fetch PC, drives a req/gnt/rvalid instruction-memory port and
//  presents one registered instruction + PC per cycle to dec0. Redirects on branch_v_q_i from EXE,
//  discards in-flight fetches on redirect and injects NOP bubbles when no valid instruction exists.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  first fetch address after reset
// PORTS
//  clk                 in   1     clock
//  reset_n             in   1     asynchronous, active-low reset
//  imem_req_o          out  1     fetch request, held until imem_gnt_i
//  imem_adr_o          out  XLEN  fetch address, stable while imem_req_o high
//  imem_gnt_i          in   1     request accepted this cycle
//  imem_rvalid_i       in   1     response valid (earliest the cycle after gnt)
//  imem_rdata_i        in   XLEN  instruction word
//  stall_i             in   1     downstream hold: output registers keep their value
//  branch_v_q_i        in   1     redirect from EXE
//  branch_target_q_i   in   XLEN  redirect address
//  instr_q_o           out  XLEN  instruction to dec0 (NOP_INSTR when invalid)
//  pc_q_o              out  XLEN  PC of instr_q_o
//  instr_v_q_o         out  1     instr_q_o is a real fetched instruction
//  instr_misaligned_q_o out 1     fetch-address-misaligned exception for pc_q_o
// BEHAVIOUR
//  - Reset: instr_q_o=NOP_INSTR (32'h0000_0013), pc_q_o=0, instr_v_q_o=0, instr_misaligned_q_o=0,
//    imem_req_o=0, fetch_pc=RESET_VECTOR, skid empty, drop=0, state=ST_BOOT.
//  - imem_req_o = (state==ST_REQ); imem_adr_o = fetch_pc. Max one outstanding request.
//  - FSM: ST_BOOT -> ST_REQ (one cycle after reset release).
//    ST_REQ: gnt -> ST_WAIT, fetch_pc += 4 (wraps at 2^XLEN).
//    ST_WAIT: rvalid & !drop -> ST_REQ if response accepted by output reg, else ST_HOLD.
//             rvalid & drop -> ST_REQ, drop cleared, data discarded.
//    ST_HOLD: skid full, no request; !stall_i -> skid moves to output, ST_REQ.
//  - Output reg loads when !stall_i: skid data if skid full, else accepted rvalid data, else NOP
//    with instr_v_q_o=0. Under stall_i a response lands in the 1-entry skid; output unchanged.
//  - Fetch latency: gnt in cycle N, rvalid in N+1 -> instr_q_o valid in N+2 (no stall).
//  - Redirect (branch_v_q_i): highest priority, overrides stall_i. Same cycle: fetch_pc <= target,
//    skid cleared; next cycle instr_v_q_o=0, instr_q_o=NOP. State -> ST_REQ, except:
//    in ST_WAIT without simultaneous rvalid, or ST_REQ with simultaneous gnt -> drop=1, ST_WAIT.
//    rvalid coinciding with redirect: data discarded, no drop set.
//  - Second redirect while drop=1: drop stays 1 (single stale response), fetch_pc updated.
//  - Reset asserted mid-transaction: all state to reset values; memory must drop outstanding req.
// CONFIGURATION
//  IFETCH_MISALIGN_CHK_EN defined: redirect with target[1:0]!=0 issues no fetch; next output cycle
//    presents pc_q_o=target, instr_q_o=NOP, instr_v_q_o=0, instr_misaligned_q_o=1 (one cycle,
//    held under stall); FSM parks in ST_REQ with req low until next redirect.
//  Not defined: target[1:0] forced to 2'b00, instr_misaligned_q_o tied 0.
// STRUCTURE
//  riscv_pkg: XLEN, NOP_INSTR constant, ifetch_state_e enum (ST_BOOT/ST_REQ/ST_WAIT/ST_HOLD).
//  Single module; skid entry and drop flag inline, no sub-module.
// TESTING
//  1 reset release, gnt/rvalid immediate -> adr 0,4,8..; instr_q_o valid 2 cycles after each gnt.
//  2 gnt delayed 3 cycles -> imem_adr_o/req stable all 3 cycles; fetch_pc increments once.
//  3 stall_i high as rvalid(0xABCD_0093) arrives -> ST_HOLD, no req; on release instr_q_o=0xABCD_0093.
//  4 redirect to 0x100 in ST_WAIT, stale rvalid next cycle -> discarded, next req adr 0x100, NOP out.
//  5 redirect coincident with rvalid -> data dropped, drop=0, req 0x100 next cycle.
//  6 redirect to 0x102: macro on -> misaligned=1, pc_q_o=0x102, no req; off -> req adr 0x100.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: datapath width, the canonical NOP and fetch-stage state/payload types.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: single-outstanding req/gnt/rvalid fetch with 1-entry skid and redirect drop.
// Optional IFETCH_MISALIGN_CHK_EN: misaligned redirect targets raise a fetch-misaligned exception.
module ifetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            stall_i,
  input  logic            branch_v_q_i,
  input  logic [XLEN-1:0] branch_target_q_i,
  output logic [XLEN-1:0] instr_q_o,
  output logic [XLEN-1:0] pc_q_o,
  output logic            instr_v_q_o,
  output logic            instr_misaligned_q_o
);

  ifetch_state_e   state, state_d;
  logic            drop, drop_d;
  logic            parked, parked_d;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  fetch_pkt_t      skid;

  logic [XLEN-1:0] target_c;
  logic            misalign_c;
  logic            gnt_c;
  logic            rvalid_c;
  logic            resp_ok_c;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign target_c   = branch_target_q_i;
  assign misalign_c = branch_v_q_i && (branch_target_q_i[1:0] != 2'b00);
`else
  assign target_c   = branch_target_q_i & ~XLEN'(32'h3);
  assign misalign_c = 1'b0;
`endif

  assign gnt_c      = (state == ST_REQ) && imem_req_o && imem_gnt_i;
  assign rvalid_c   = (state == ST_WAIT) && imem_rvalid_i;
  assign resp_ok_c  = rvalid_c && !drop && !branch_v_q_i;
  assign imem_adr_o = fetch_pc;

  // Next-state: a redirect wins; an in-flight request turns into a single stale response to drop.
  always_comb begin
    state_d  = state;
    drop_d   = drop;
    parked_d = parked;
    if (branch_v_q_i) begin
      parked_d = misalign_c;
      if (((state == ST_WAIT) && !rvalid_c) || gnt_c) begin
        state_d = ST_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end
    end else begin
      case (state)
        ST_BOOT: state_d = ST_REQ;
        ST_REQ:  if (gnt_c) state_d = ST_WAIT;
        ST_WAIT: begin
          if (rvalid_c) begin
            drop_d  = 1'b0;
            state_d = (drop || !stall_i) ? ST_REQ : ST_HOLD;
          end
        end
        ST_HOLD: if (!stall_i) state_d = ST_REQ;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= ST_BOOT;
      drop                 <= 1'b0;
      parked               <= 1'b0;
      imem_req_o           <= 1'b0;
      fetch_pc             <= RESET_VECTOR;
      req_pc               <= '0;
      skid                 <= '0;
      instr_q_o            <= NOP_INSTR;
      pc_q_o               <= '0;
      instr_v_q_o          <= 1'b0;
      instr_misaligned_q_o <= 1'b0;
    end else begin
      state      <= state_d;
      drop       <= drop_d;
      parked     <= parked_d;
      imem_req_o <= (state_d == ST_REQ) && !parked_d;

      if (branch_v_q_i) begin
        fetch_pc <= target_c;
      end else if (gnt_c) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (gnt_c) begin
        req_pc <= fetch_pc;
      end

      if (resp_ok_c && stall_i) begin
        skid <= '{pc: req_pc, instr: imem_rdata_i};
      end

      // Output register: redirect bubble, then skid, then fresh response, else NOP.
      if (branch_v_q_i) begin
        pc_q_o               <= target_c;
        instr_q_o            <= NOP_INSTR;
        instr_v_q_o          <= 1'b0;
        instr_misaligned_q_o <= misalign_c;
      end else if (!stall_i) begin
        instr_misaligned_q_o <= 1'b0;
        if (state == ST_HOLD) begin
          pc_q_o      <= skid.pc;
          instr_q_o   <= skid.instr;
          instr_v_q_o <= 1'b1;
        end else if (resp_ok_c) begin
          pc_q_o      <= req_pc;
          instr_q_o   <= imem_rdata_i;
          instr_v_q_o <= 1'b1;
        end else begin
          instr_q_o   <= NOP_INSTR;
          instr_v_q_o <= 1'b0;
        end
      end
    end
  end

endmodule
